mole_picker: RTL and testbench

Parametrised successor to the whack-a-mole random LED picker. It drives a one-hot "mole" across `N_HOLES` LEDs, chosen by an internal LFSR using bias-free rejection sampling. The mole stays lit for a bounded lifetime and the block scores hits against player switches. It sits between the trigger/switch inputs and the LED bank, and feeds the score/round logic through single-cycle `hit_pulse`/`miss_pulse`.

---
 rtl/mole_pkg.sv | 24 ++
 rtl/lfsr_gen.sv | 26 ++
 rtl/mole_picker.sv | 135 +++++++++++++
 tb/tb_mole_picker.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// Shared state encoding, default geometry and LFSR tap masks for the mole picker
// and the other random blocks built on lfsr_gen.
package mole_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PICK,
    ST_SHOW
  } state_t;

  localparam int unsigned N_HOLES_DEF = 18;

  // Galois right-shift tap masks, maximal length for each supported width
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    case (width)
      8:       lfsr_taps = 32'h0000_00B8;
      16:      lfsr_taps = 32'h0000_B400;
      24:      lfsr_taps = 32'h00E1_0000;
      32:      lfsr_taps = 32'h8020_0003;
      default: lfsr_taps = 32'h0000_B400;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running maximal-length Galois LFSR; a zero seed is forced to 1 so the
// register can never lock up in the all-zero state.
module lfsr_gen
  import mole_pkg::*;
#(
  parameter int unsigned       LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] out
);

  localparam logic [31:0]       TAPS_ALL = lfsr_taps(LFSR_W);
  localparam logic [LFSR_W-1:0] TAPS     = TAPS_ALL[LFSR_W-1:0];
  localparam logic [LFSR_W-1:0] SEED_FIX = (SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : SEED;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out <= SEED_FIX;
    end else begin
      out <= (out >> 1) ^ (out[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/mole_picker.sv
// One-hot mole picker: LFSR rejection sampling, bounded lifetime, hit/miss scoring.
// Optional MOLE_NO_REPEAT_EN forbids the same hole twice in a row.
module mole_picker
  import mole_pkg::*;
#(
  parameter int unsigned       N_HOLES     = N_HOLES_DEF,
  parameter int unsigned       LFSR_W      = 16,
  parameter logic [LFSR_W-1:0] SEED        = 16'hACE1,
  parameter int unsigned       LIFE_CYCLES = 50_000_000,
  localparam int unsigned      IDX_W       = $clog2(N_HOLES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trigger,
  input  logic [N_HOLES-1:0] hit,
  output logic [N_HOLES-1:0] displayL,
  output logic [IDX_W-1:0]   mole_idx,
  output logic               busy,
  output logic               hit_pulse,
  output logic               miss_pulse
);

  localparam int unsigned       CNT_W    = (LIFE_CYCLES > 1) ? $clog2(LIFE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  LIFE_TOP = CNT_W'(LIFE_CYCLES - 1);
  localparam logic [N_HOLES-1:0] ONE_HOT0 = N_HOLES'(1);

  state_t              state, state_nxt;
  logic                trig_q;
  logic [CNT_W-1:0]    life_cnt, life_nxt;
  logic [N_HOLES-1:0]  disp_nxt;
  logic [IDX_W-1:0]    idx_nxt;
  logic                busy_nxt, hitp_nxt, missp_nxt;
  logic [LFSR_W-1:0]   lfsr;
  logic [IDX_W-1:0]    cand;
  logic                cand_ok;
  logic                rise;
  logic                mole_hit;

  lfsr_gen #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .out   (lfsr)
  );

  assign cand     = lfsr[IDX_W-1:0];
  assign rise     = trigger & ~trig_q;
  assign mole_hit = hit[mole_idx];

`ifdef MOLE_NO_REPEAT_EN
  assign cand_ok = (32'(cand) < N_HOLES) && (cand != mole_idx);
`else
  assign cand_ok = (32'(cand) < N_HOLES);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      trig_q     <= 1'b0;
      life_cnt   <= '0;
      displayL   <= '0;
      mole_idx   <= '0;
      busy       <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      trig_q     <= trigger;
      life_cnt   <= life_nxt;
      displayL   <= disp_nxt;
      mole_idx   <= idx_nxt;
      busy       <= busy_nxt;
      hit_pulse  <= hitp_nxt;
      miss_pulse <= missp_nxt;
    end
  end

  // Abort outranks hit, which outranks timeout, all decided in one cycle
  always_comb begin
    state_nxt = state;
    life_nxt  = life_cnt;
    disp_nxt  = displayL;
    idx_nxt   = mole_idx;
    hitp_nxt  = 1'b0;
    missp_nxt = 1'b0;

    unique case (state)
      ST_IDLE: begin
        disp_nxt = '0;
        if (rise) begin
          state_nxt = ST_PICK;
        end
      end

      ST_PICK: begin
        if (!trigger) begin
          state_nxt = ST_IDLE;
          disp_nxt  = '0;
        end else if (cand_ok) begin
          idx_nxt   = cand;
          disp_nxt  = ONE_HOT0 << cand;
          life_nxt  = LIFE_TOP;
          state_nxt = ST_SHOW;
        end
      end

      ST_SHOW: begin
        if (!trigger) begin
          state_nxt = ST_IDLE;
          disp_nxt  = '0;
        end else if (mole_hit) begin
          hitp_nxt  = 1'b1;
          disp_nxt  = '0;
          state_nxt = ST_IDLE;
        end else if (life_cnt == '0) begin
          missp_nxt = 1'b1;
          disp_nxt  = '0;
          state_nxt = ST_IDLE;
        end else begin
          life_nxt = life_cnt - 1'b1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        disp_nxt  = '0;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_mole_picker.sv
// Scoreboard bench for mole_picker (N_HOLES=18, LIFE_CYCLES=8): stimulus predicts
// each round's events into a queue, a negedge monitor pops and compares them.
module tb_mole_picker;

  localparam int N = 18;
  localparam int L = 8;

  typedef enum int {EV_ON, EV_HIT, EV_MISS, EV_ABORT} ev_t;
  typedef struct {
    ev_t kind;
    int  cyc;
    int  idx;
  } exp_t;

  typedef enum int {M_MISS, M_HIT3, M_HITLAST, M_WRONG, M_ABORT, M_FAST, M_RESET} mode_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         trigger = 1'b0;
  logic [N-1:0] hit = '0;
  logic [N-1:0] displayL;
  logic [4:0]   mole_idx;
  logic         busy;
  logic         hit_pulse;
  logic         miss_pulse;

  mole_picker #(
    .N_HOLES     (N),
    .LFSR_W      (16),
    .SEED        (16'hACE1),
    .LIFE_CYCLES (L)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .trigger    (trigger),
    .hit        (hit),
    .displayL   (displayL),
    .mole_idx   (mole_idx),
    .busy       (busy),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t q[$];
  int   last_idx = 0;
  bit   seen [N];
  int   out_of_range = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR x^16+x^14+x^13+x^11+1, Galois right-shift form
  function automatic logic [15:0] step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= 16'hACE1;
    else        m_lfsr <= step(m_lfsr);
  end

  function automatic bit acceptable(input int c, input int prev);
`ifdef MOLE_NO_REPEAT_EN
    return (c < N) && (c != prev);
`else
    return (c < N) && (prev >= 0);
`endif
  endfunction

  task automatic push(input ev_t k, input int c, input int idx);
    exp_t e;
    e.kind = k;
    e.cyc  = c;
    e.idx  = idx;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: classify what the DUT shows this cycle and compare with the queue head
  logic prev_on = 1'b0;
  int   prev_idx = 0;
  ev_t  m_kind;
  bit   m_got;
  bit   m_shape;
  int   m_idx;
  exp_t m_e;

  always @(negedge clk) begin
    m_got   = 1'b0;
    m_shape = 1'b1;
    m_kind  = EV_ON;
    m_idx   = int'(mole_idx);
    if (hit_pulse || miss_pulse) begin
      m_got   = 1'b1;
      m_kind  = hit_pulse ? EV_HIT : EV_MISS;
      m_shape = !(hit_pulse && miss_pulse) && (displayL == '0) && !busy;
    end else if (prev_on && displayL == '0) begin
      m_got   = 1'b1;
      m_kind  = EV_ABORT;
      m_shape = !busy;
    end else if (!prev_on && displayL != '0) begin
      m_got   = 1'b1;
      m_kind  = EV_ON;
      m_shape = (displayL == (18'd1 << mole_idx)) && busy;
      if (m_idx < N) seen[m_idx] = 1'b1;
      else           out_of_range++;
`ifdef MOLE_NO_REPEAT_EN
      n_total++;
      if (m_idx != prev_idx) n_pass++;
      else $display("FAIL repeat: idx=%0d, required different from previous %0d", m_idx, prev_idx);
`endif
      prev_idx = m_idx;
    end
    if (!reset) prev_idx = 0;
    prev_on = |displayL;

    if (m_got) begin
      n_total++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_event: got %s at cyc=%0d idx=%0d, required no event",
                 m_kind.name(), cyc, m_idx);
      end else begin
        m_e = q.pop_front();
        if (m_e.kind == m_kind && m_e.cyc == cyc && (m_kind != EV_ON || m_e.idx == m_idx) && m_shape)
          n_pass++;
        else
          $display("FAIL event: got %s cyc=%0d idx=%0d disp=%h busy=%0d shape_ok=%0d, required %s cyc=%0d idx=%0d",
                   m_kind.name(), cyc, m_idx, displayL, busy, m_shape, m_e.kind.name(), m_e.cyc, m_e.idx);
      end
    end
  end

  task automatic check_idle(input string name);
    n_total++;
    if (displayL == '0 && !busy && !hit_pulse && !miss_pulse && mole_idx == '0)
      n_pass++;
    else
      $display("FAIL %s: disp=%h busy=%0d hit_p=%0d miss_p=%0d idx=%0d, required all zero",
               name, displayL, busy, hit_pulse, miss_pulse, mole_idx);
  endtask

  // One round: raise trigger, predict the accepted hole and its light-up cycle, then finish per mode
  task automatic run_round(input mode_t mode, input bit hold);
    logic [15:0] v;
    int k, s, idx;
    @(negedge clk);
    trigger = 1'b1;
    v = step(m_lfsr);
    k = 0;
    while (!acceptable(int'(v[4:0]), last_idx)) begin
      v = step(v);
      k++;
    end
    idx = int'(v[4:0]);
    last_idx = idx;
    s = cyc + 2 + k;
    push(EV_ON, s, idx);
    case (mode)
      M_MISS: begin
        push(EV_MISS, s + L, idx);
        wait_cyc(s + L);
      end
      M_HIT3: begin
        wait_cyc(s + 2);
        hit = 18'd1 << idx;
        push(EV_HIT, s + 3, idx);
        wait_cyc(s + 3);
      end
      M_HITLAST: begin
        wait_cyc(s + L - 1);
        hit = 18'd1 << idx;
        push(EV_HIT, s + L, idx);
        wait_cyc(s + L);
      end
      M_WRONG: begin
        wait_cyc(s);
        hit = ~(18'd1 << idx);
        push(EV_MISS, s + L, idx);
        wait_cyc(s + L);
      end
      M_ABORT: begin
        wait_cyc(s + 2);
        trigger = 1'b0;
        push(EV_ABORT, s + 3, idx);
        wait_cyc(s + 3);
      end
      M_FAST: begin
        wait_cyc(s);
        hit = 18'd1 << idx;
        push(EV_HIT, s + 1, idx);
        wait_cyc(s + 1);
      end
      M_RESET: begin
        wait_cyc(s + 2);
        #2;
        reset   = 1'b0;
        trigger = 1'b0;
        push(EV_ABORT, s + 3, idx);
        #1;
        check_idle("async_reset");
        last_idx = 0;
        wait_cyc(s + 4);
        reset = 1'b1;
      end
      default: ;
    endcase
    hit = '0;
    if (!hold) trigger = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    last_idx = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_idle("reset_idle");
    end

    run_round(M_MISS, 1'b0);
    run_round(M_HIT3, 1'b0);
    run_round(M_HITLAST, 1'b0);
    run_round(M_WRONG, 1'b0);
    run_round(M_ABORT, 1'b0);
    run_round(M_FAST, 1'b0);

    // Held trigger must not re-arm: any event in this window is unexpected
    run_round(M_MISS, 1'b1);
    repeat (20) @(negedge clk);
    trigger = 1'b0;

    run_round(M_RESET, 1'b0);
    run_round(M_MISS, 1'b0);

    for (int r = 0; r < 2000; r++) run_round(M_FAST, 1'b0);

    repeat (5) @(negedge clk);

    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL pending_events: %0d left, required 0", q.size());

    for (int i = 0; i < N; i++) begin
      n_total++;
      if (seen[i]) n_pass++;
      else $display("FAIL coverage_idx%0d: seen=0, required 1", i);
    end

    n_total++;
    if (out_of_range == 0) n_pass++;
    else $display("FAIL range: %0d moles >= %0d, required 0", out_of_range, N);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
